// File: rtl/alu_seq.sv
// Sequential ALU with a single-cycle path for logic/add ops and iterative shift-add MUL.
// Define ALU_SEQ_DIV_EN to build the restoring divider; without it op 111 returns err=1.
module alu_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             ovf,
   output logic             err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
`ifdef ALU_SEQ_DIV_EN
   localparam logic [1:0] S_DIV  = 2'd2;
`endif
   localparam logic [1:0] S_DONE = 2'd3;
   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   // opr holds the multiplicand (MUL) or divisor (DIV); {hi,lo} is the shared shift register
   logic [WIDTH-1:0] opr, hi, lo;

   logic [WIDTH-1:0] imm_res;
   logic             imm_ovf, imm_err;

   always_comb begin
      imm_res = '0;
      imm_ovf = 1'b0;
      imm_err = 1'b0;
      case (op)
         3'b000: imm_res = ~a;
         3'b001: imm_res = a | b;
         3'b010: imm_res = a & b;
         3'b011: begin
            imm_res = '0 - a;
            imm_ovf = (a == SMIN);
         end
         3'b100: begin
            imm_res = a + b;
            imm_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (imm_res[WIDTH-1] != a[WIDTH-1]);
         end
         3'b101: begin
            imm_res = a - b;
            imm_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (imm_res[WIDTH-1] != a[WIDTH-1]);
         end
         3'b111: imm_err = 1'b1;
         default: imm_res = '0;
      endcase
   end

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mul_hi_nxt, mul_lo_nxt;
   assign mul_sum    = {1'b0, hi} + (lo[0] ? {1'b0, opr} : {(WIDTH+1){1'b0}});
   assign mul_hi_nxt = mul_sum[WIDTH:1];
   assign mul_lo_nxt = {mul_sum[0], lo[WIDTH-1:1]};

`ifdef ALU_SEQ_DIV_EN
   logic [WIDTH:0]   div_rs, div_diff;
   logic [WIDTH-1:0] div_hi_nxt, div_lo_nxt;
   assign div_rs   = {hi, lo[WIDTH-1]};
   assign div_diff = div_rs - {1'b0, opr};
   // bit WIDTH of the difference is the borrow: set means the trial subtract failed
   assign div_hi_nxt = div_diff[WIDTH] ? div_rs[WIDTH-1:0] : div_diff[WIDTH-1:0];
   assign div_lo_nxt = {lo[WIDTH-2:0], ~div_diff[WIDTH]};
`endif

   assign in_ready  = (state == S_IDLE) && !rst;
   assign out_valid = (state == S_DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         cnt    <= '0;
         opr    <= '0;
         hi     <= '0;
         lo     <= '0;
         result <= '0;
         zero   <= 1'b0;
         ovf    <= 1'b0;
         err    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (in_valid) begin
               cnt <= '0;
               case (op)
                  3'b110: begin
                     state <= S_MUL;
                     opr   <= a;
                     hi    <= '0;
                     lo    <= b;
                  end
`ifdef ALU_SEQ_DIV_EN
                  3'b111: if (b == '0) begin
                     state  <= S_DONE;
                     result <= '1;
                     zero   <= 1'b0;
                     ovf    <= 1'b0;
                     err    <= 1'b1;
                  end else begin
                     state <= S_DIV;
                     opr   <= b;
                     hi    <= '0;
                     lo    <= a;
                  end
`endif
                  default: begin
                     state  <= S_DONE;
                     result <= imm_res;
                     zero   <= (imm_res == '0);
                     ovf    <= imm_ovf;
                     err    <= imm_err;
                  end
               endcase
            end
            S_MUL: begin
               hi  <= mul_hi_nxt;
               lo  <= mul_lo_nxt;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH-1)) begin
                  state  <= S_DONE;
                  result <= mul_lo_nxt;
                  zero   <= (mul_lo_nxt == '0);
                  ovf    <= (mul_hi_nxt != '0);
                  err    <= 1'b0;
               end
            end
`ifdef ALU_SEQ_DIV_EN
            S_DIV: begin
               hi  <= div_hi_nxt;
               lo  <= div_lo_nxt;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH-1)) begin
                  state  <= S_DONE;
                  result <= div_lo_nxt;
                  zero   <= (div_lo_nxt == '0);
                  ovf    <= 1'b0;
                  err    <= 1'b0;
               end
            end
`endif
            S_DONE: if (out_ready) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=32); expectations follow ALU_SEQ_DIV_EN if defined.
module tb_alu_seq;

   logic        clk, rst, in_valid, in_ready, out_valid, out_ready, zero, ovf, err;
   logic [31:0] a, b, result;
   logic [2:0]  op;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      logic [31:0] r;
      logic        z, v, e;
      int          lat;
   } exp_t;

   exp_t sb[$];

   alu_seq #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .ovf(ovf), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [31:0] ta, input logic [31:0] tb, input logic [2:0] top);
      exp_t   e;
      longint sa, sb2, s;
      logic [63:0] p;
      sa  = longint'($signed(ta));
      sb2 = longint'($signed(tb));
      e.r = '0; e.v = 1'b0; e.e = 1'b0; e.lat = 1;
      case (top)
         3'd0: e.r = ~ta;
         3'd1: e.r = ta | tb;
         3'd2: e.r = ta & tb;
         3'd3: begin s = -sa; e.r = s[31:0]; e.v = (s > 64'sd2147483647); end
         3'd4: begin s = sa + sb2; e.r = s[31:0]; e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
         3'd5: begin s = sa - sb2; e.r = s[31:0]; e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
         3'd6: begin p = {32'b0, ta} * {32'b0, tb}; e.r = p[31:0]; e.v = (p[63:32] != 0); e.lat = 33; end
         default: begin
`ifdef ALU_SEQ_DIV_EN
            if (tb == 0) begin e.r = 32'hFFFF_FFFF; e.e = 1'b1; end
            else begin e.r = ta / tb; e.lat = 33; end
`else
            e.e = 1'b1;
`endif
         end
      endcase
      e.z = (e.r == 0);
      return e;
   endfunction

   task automatic do_op(input logic [31:0] ta, input logic [31:0] tb, input logic [2:0] top, input int hold);
      exp_t e;
      int   lat;
      sb.push_back(model(ta, tb, top));
      @(negedge clk);
      a = ta; b = tb; op = top; in_valid = 1'b1; out_ready = 1'b0;
      chk("in_ready_idle", in_ready, 1);
      @(posedge clk); #1;
      // garbage on the inputs while busy must be ignored
      a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
      lat = 1;
      while (!out_valid && lat < 200) begin
         chk("in_ready_busy", in_ready, 0);
         @(posedge clk); #1;
         lat++;
      end
      e = sb.pop_front();
      chk("latency", lat, e.lat);
      chk("result", result, e.r);
      chk("zero", zero, e.z);
      chk("ovf", ovf, e.v);
      chk("err", err, e.e);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_valid", out_valid, 1);
         chk("hold_result", result, e.r);
         chk("hold_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk("post_valid", out_valid, 0);
      chk("post_ready", in_ready, 1);
   endtask

   initial begin
      int seen;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", in_ready, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_flags", {zero, ovf, err}, 0);
      @(negedge clk); rst = 1'b0; #1;
      chk("rel_ready", in_ready, 1);

      do_op(32'h7FFF_FFFF, 32'h0000_0001, 3'd4, 0);
      do_op(32'h0001_0000, 32'h0001_0000, 3'd6, 0);
      do_op(32'd100, 32'd7, 3'd7, 0);
      do_op(32'd5, 32'd0, 3'd7, 0);
      do_op(32'd3, 32'd5, 3'd5, 5);
      do_op(32'hF0F0_F0F0, 32'hFF00_FF00, 3'd2, 0);
      do_op(32'hF0F0_F0F0, 32'h0F0F_0000, 3'd1, 0);
      do_op(32'h1234_5678, 32'h0, 3'd0, 0);
      do_op(32'h0000_0005, 32'h0, 3'd3, 0);
      do_op(32'h8000_0000, 32'h1, 3'd5, 0);
      do_op(32'd1234, 32'd5678, 3'd6, 0);
      do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd6, 1);
      do_op(32'hFFFF_FFFF, 32'd1, 3'd7, 0);
      do_op(32'hFFFF_FFFF, 32'h0001_0000, 3'd7, 0);
      do_op(32'h8000_0000, 32'h0, 3'd3, 0);

      // reset in the middle of a MUL: abandon it, nothing comes out afterwards
      @(negedge clk);
      a = 32'h0001_0000; b = 32'h0001_0000; op = 3'd6; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("mrst_valid", out_valid, 0);
      chk("mrst_result", result, 0);
      chk("mrst_flags", {zero, ovf, err}, 0);
      chk("mrst_ready", in_ready, 0);
      @(negedge clk); rst = 1'b0; #1;
      chk("mrst_rel_ready", in_ready, 1);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      chk("mrst_no_valid", seen, 0);
      do_op(32'hF0F0_F0F0, 32'hFF00_FF00, 3'd2, 0);

      for (int i = 0; i < 10; i++)
         do_op($urandom, $urandom, 3'($urandom_range(0, 7)), i % 3);

      chk("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits (legal range 4..64).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: in_valid  input  1  request strobe; a, b and op are valid.
REQ-005 Port: in_ready  output  1  block can accept a request.
REQ-006 Port: a  input  WIDTH  operand 1.
REQ-007 Port: b  input  WIDTH  operand 2.
REQ-008 Port: op  input  3  opcode (000 NOT a, 001 OR, 010 AND, 011 NEG a, 100 ADD, 101 SUB, 110 MUL, 111 DIV).
REQ-009 Port: out_valid  output  1  result and flags valid.
REQ-010 Port: out_ready  input  1  consumer accepts result.
REQ-011 Port: result  output  WIDTH  operation result.
REQ-012 Port: zero  output  1  result equals 0.
REQ-013 Port: ovf  output  1  signed overflow (ADD/SUB/NEG) or nonzero high half (MUL).
REQ-014 Port: err  output  1  divide by zero, or DIV requested while DIV is compiled out.

Function
REQ-015 Request accepted on a rising edge with in_valid=1 and in_ready=1; operands and op are registered at acceptance and later input changes are ignored.
REQ-016 FSM states: IDLE, MUL, DIV, DONE; in_ready=1 only in IDLE.
REQ-017 IDLE->DONE on acceptance of ops 000-101 (result computed in the accepting cycle); IDLE->MUL on op 110; IDLE->DIV on op 111.
REQ-018 Ops 000-101: out_valid=1 on the first edge after acceptance (latency 1).
REQ-019 NEG = two's complement (0 - a); ADD/SUB modulo 2^WIDTH; ovf = signed overflow; NEG ovf=1 only for a = 100..0.
REQ-020 MUL: iterative shift-add, one bit per cycle, WIDTH cycles in MUL, then DONE; out_valid at edge WIDTH+1 after acceptance; result = low WIDTH bits of unsigned product; ovf=1 iff high WIDTH bits nonzero.
REQ-021 DIV: unsigned restoring division, one bit per cycle, WIDTH cycles in DIV, then DONE; latency WIDTH+1; result = quotient; remainder discarded.
REQ-022 DIV with b=0: skip iteration, go directly to DONE (latency 1), result = all ones, err=1.
REQ-023 Logic ops, NEG with a != 100..0, and DIV without divide-by-zero: ovf=0; err=0 for every op except the cases in REQ-014.
REQ-024 zero computed from the final result for every op.
REQ-025 DONE: out_valid=1; result and flags held stable until out_valid&&out_ready on an edge, then DONE->IDLE; no new request accepted in the same cycle.
REQ-026 in_valid while not in IDLE has no effect; requests are never queued or dropped silently (in_ready=0 signals backpressure).
REQ-027 out_valid=0 in all states except DONE; result/flags are don't-care while out_valid=0, but hold their last value.

Reset
REQ-028 rst=1 immediately (asynchronously) forces state IDLE, iteration counter 0, result 0, zero/ovf/err 0, out_valid 0, regardless of state.
REQ-029 in_ready=0 while rst=1; in_ready=1 from the first cycle after rst deasserts.
REQ-030 Reset during MUL/DIV/DONE abandons the operation; no out_valid is produced for it.

Configuration
REQ-031 Macro ALU_SEQ_DIV_EN defined: DIV state and divider datapath present, behaviour per REQ-021/022.
REQ-032 ALU_SEQ_DIV_EN undefined: no DIV state or divider logic; op 111 goes IDLE->DONE with latency 1, result 0, err=1, zero=1, ovf=0.

Verification (WIDTH=32)
REQ-033 ADD a=0x7FFFFFFF, b=0x00000001 -> result 0x80000000, ovf=1, zero=0, out_valid 1 cycle after acceptance.
REQ-034 MUL a=0x00010000, b=0x00010000 -> result 0x00000000, zero=1, ovf=1, out_valid exactly 33 cycles after acceptance, in_ready=0 throughout.
REQ-035 DIV a=100, b=7 -> result 14, err=0, latency 33; DIV a=5, b=0 -> result 0xFFFFFFFF, err=1, latency 1 (macro defined).
REQ-036 SUB a=3, b=5 with out_ready held 0 for 5 cycles -> result 0xFFFFFFFE held stable with out_valid=1, in_ready=0; IDLE the cycle after out_ready=1.
REQ-037 rst pulsed mid-MUL (cycle 10 of iteration) -> all outputs 0 immediately, no out_valid afterwards, in_ready=1 first cycle after release; a subsequent AND 0xF0F0F0F0 & 0xFF00FF00 -> 0xF000F000.
REQ-038 Macro undefined: DIV a=100, b=7 -> result 0, err=1, zero=1, latency 1.
